night_clock_ctrl: RTL

Game-night clock controller for the time overlay. Counts video frames into in-game hours (12 AM through 6 AM) and sequences the hour counter through a start/pause/done state machine. Generates the address into the shared 7-frame time sprite ROM for a fixed on-screen window, so the overlay always shows the current hour. Sits between the VGA timing generator (DrawX/DrawY) and the time sprite ROM/palette, and signals night completion to the game FSM.

---
 rtl/night_clock_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/night_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : night_clock_ctrl
// Brief   : Counts frames into in-game hours and addresses the time sprite ROM.
// Revision: 1.0
// ============================================================================
module night_clock_ctrl #(
  parameter int FRAMES_PER_HOUR = 5400,
  parameter int LAST_HOUR       = 6,
  parameter int WIN_X           = 560,
  parameter int WIN_Y           = 16,
  parameter int SPR_W           = 29,
  parameter int SPR_H           = 30
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        start,
  input  logic        pause,
  output logic [2:0]  hour,
  output logic        running,
  output logic        frame_tick,
  output logic        hour_tick,
  output logic        night_done,
  output logic        in_window,
  output logic [12:0] rom_address
);

  localparam logic [15:0] FPH_M1      = 16'(FRAMES_PER_HOUR - 1);
  localparam logic [2:0]  LAST        = 3'(LAST_HOUR);
  localparam logic [9:0]  VBLANK_ROW  = 10'd480;
  localparam logic [9:0]  X0          = 10'(WIN_X);
  localparam logic [9:0]  X1          = 10'(WIN_X + SPR_W);
  localparam logic [9:0]  Y0          = 10'(WIN_Y);
  localparam logic [9:0]  Y1          = 10'(WIN_Y + SPR_H);
  localparam logic [12:0] HOUR_STRIDE = 13'(SPR_W * SPR_H);
  localparam logic [12:0] ROW_STRIDE  = 13'(SPR_W);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  hour_nxt;
  logic [15:0] frame_cnt, frame_cnt_nxt;
  logic [9:0]  prev_y;
  logic        frame_tick_nxt, hour_tick_nxt, night_done_nxt;
  logic [12:0] dx, dy;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hour       <= '0;
      frame_cnt  <= '0;
      prev_y     <= '0;
      frame_tick <= 1'b0;
      hour_tick  <= 1'b0;
      night_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      hour       <= hour_nxt;
      frame_cnt  <= frame_cnt_nxt;
      prev_y     <= DrawY;
      frame_tick <= frame_tick_nxt;
      hour_tick  <= hour_tick_nxt;
      night_done <= night_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hour_nxt       = hour;
    frame_cnt_nxt  = frame_cnt;
    hour_tick_nxt  = 1'b0;
    night_done_nxt = 1'b0;
    frame_tick_nxt = (DrawY == VBLANK_ROW) && (prev_y != VBLANK_ROW);

    case (state)
      RUN: begin
        // A tick arriving together with pause is still counted before pausing.
        if (frame_tick) begin
          if (frame_cnt == FPH_M1) begin
            frame_cnt_nxt = '0;
            hour_nxt      = hour + 3'd1;
            hour_tick_nxt = 1'b1;
            if (hour_nxt == LAST) begin
              state_nxt      = DONE;
              night_done_nxt = 1'b1;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + 16'd1;
          end
        end
        if (state_nxt == RUN && pause) state_nxt = PAUSED;
      end
      IDLE, PAUSED, DONE: begin
        if (start) begin
          hour_nxt      = '0;
          frame_cnt_nxt = '0;
          state_nxt     = pause ? PAUSED : RUN;
        end else if (state == PAUSED && !pause) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);

  // Address is combinational so the negedge-sampled ROM returns same-cycle data.
  assign in_window = (DrawX >= X0) && (DrawX < X1) && (DrawY >= Y0) && (DrawY < Y1);
  assign dx = 13'(DrawX - X0);
  assign dy = 13'(DrawY - Y0);
  assign rom_address = in_window ? (13'(hour) * HOUR_STRIDE + dy * ROW_STRIDE + dx) : 13'd0;

endmodule
`default_nettype wire
